eprisc_bus_arbiter: RTL
=======================

// Module: eprisc_bus_arbiter
// PURPOSE
//   Shares the single epRISC system bus (address, data, write strobe) between NREQ masters:
//   the core, debug port, DMA and others. Round-robin arbitration with an optional lock for
//   read-modify-write sequences. Registers each granted transaction onto the bus and waits
//   for slave ready. Aborts with an error if the slave stalls too long.
//   Sits between the masters and the memory/peripheral decode.
// PARAMETERS
//   NREQ     4    number of requesting masters (2..8); index 0 is the core
//   TIMEOUT  16   max cycles in sBus without iBusReady before abort (>=2)
// PORTS
//   iClk       in   1        clock; all logic on posedge
//   iRst       in   1        reset, synchronous, active-high
//   iReq       in   NREQ     per-master request; held stable with its fields until oAck
//   iLock      in   NREQ     per-master lock: keep grant for next transaction
//   iWrite     in   NREQ     per-master write (1) / read (0)
//   iAddr      in   32*NREQ  per-master address; master k = bits [32k+31:32k]
//   iWData     in   32*NREQ  per-master write data, same packing
//   oGnt       out  NREQ     one-hot grant; owner of current transaction
//   oAck       out  NREQ     one-cycle completion pulse to owner
//   oErr       out  1        valid with oAck: 1 = timeout abort
//   oRData     out  32       read data, valid while oAck is high
//   oBusValid  out  1        bus cycle in progress
//   oBusWrite  out  1        bus write strobe; 0 whenever oBusValid = 0
//   oBusAddr   out  32       bus address
//   oBusWData  out  32       bus write data
//   iBusRData  in   32       bus read data, sampled when iBusReady = 1
//   iBusReady  in   1        slave completes the cycle; ignored outside sBus
// BEHAVIOUR
//   Reset values: all outputs 0. State = sIdle, RR pointer = NREQ-1, lock flag = 0,
//   timeout counter = 0.
//   FSM states:
//   - sIdle: oGnt = 0.
//     - If the lock flag is set and the locked owner's iReq = 1: regrant the same owner.
//     - Else, if any iReq = 1: grant the first requester searching upward from pointer+1
//       (mod NREQ), and set pointer = winner.
//     - On grant: latch addr, wdata and write into oBus*; set oGnt = one-hot(winner);
//       set oBusValid = 1; clear counter; go to sBus.
//     - With no request: stay in sIdle.
//   - sBus: oBusValid = 1; oBus* held constant. The counter increments each cycle.
//     - iBusReady = 1: oRData <= iBusRData (0 if write); oErr <= 0; go to sAck.
//     - Else, if counter == TIMEOUT-1: oRData <= 32'hBADC0DE; oErr <= 1; go to sAck.
//       iBusReady on the same edge as the timeout wins (normal completion).
//   - sAck: oBusValid = 0; oBusWrite = 0; oAck[owner] = 1 for exactly this cycle;
//     oGnt still held. iReq is ignored in this state; the master drops or renews iReq here.
//     - Lock flag <= iLock[owner] & ~oErr.
//     - Go to sIdle.
//   Latency: request seen in sIdle at cycle N -> oBusValid at N+1. Ready at cycle M
//   (M >= N+1) -> oAck at M+1 -> next grant decision at M+2.
//   Peak throughput: one transaction per 3 cycles.
//   Lock: the flag clears in sIdle when the owner's iReq = 0; normal round-robin then
//   applies in that same cycle. A locked owner can starve others by design; lock is for
//   short sequences only.
//   Fairness: without lock, any continuously requesting master is granted within NREQ
//   transactions.
//   Withdrawal: iReq dropping during sBus/sAck does not cancel the cycle; the ack is
//   still issued.
//   Reset mid-transaction: abandoned, no oAck; oBusValid = 0 after the reset edge.
//   Invariants: at most one bit of oGnt/oAck is set; oAck is only set where oGnt is set.
// TESTING
//   1. Single read: iReq=0001, iAddr0=0x100; iBusReady one cycle after oBusValid with
//      RData=0xCAFEF00D -> oBusAddr=0x100, oAck=0001 with oRData=0xCAFEF00D, oErr=0.
//   2. Round-robin: iReq=1111 held, ready immediate -> grant order 0,1,2,3,0;
//      each oAck 3 cycles apart.
//   3. Lock: master 2 with iLock=1 and iReq held 3 transactions while master 0 requests ->
//      three consecutive grants to 2, then master 0 granted.
//   4. Timeout: iReq=0010 write, iBusReady never -> oBusValid for exactly 16 cycles, then
//      oAck=0010, oErr=1, oRData=0xBADC0DE.
//   5. Ready on timeout edge: iBusReady at counter=TIMEOUT-1 -> oErr=0, bus data returned.
//   6. Reset mid-sBus: assert iRst with oBusValid=1 -> no oAck.
//      Next cycle all outputs 0; first post-reset grant goes to master 0.

Source files
------------

// File: rtl/eprisc_bus_arbiter.sv
// eprisc_bus_arbiter: round-robin owner of the epRISC system bus.
// Grants one master at a time and drives its transaction onto the bus. A master can
// lock the bus for the next transaction. A slave that stalls too long is aborted with
// oErr.
module eprisc_bus_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                 iClk,
   input  logic                 iRst,
   input  logic [NREQ-1:0]      iReq,
   input  logic [NREQ-1:0]      iLock,
   input  logic [NREQ-1:0]      iWrite,
   input  logic [32*NREQ-1:0]   iAddr,
   input  logic [32*NREQ-1:0]   iWData,
   output logic [NREQ-1:0]      oGnt,
   output logic [NREQ-1:0]      oAck,
   output logic                 oErr,
   output logic [31:0]          oRData,
   output logic                 oBusValid,
   output logic                 oBusWrite,
   output logic [31:0]          oBusAddr,
   output logic [31:0]          oBusWData,
   input  logic [31:0]          iBusRData,
   input  logic                 iBusReady
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT) + 1;
   localparam logic [31:0] ERR_DATA = 32'h0BADC0DE;

   typedef enum logic [1:0] {sIdle, sBus, sAck} state_t;

   state_t          state, stateNxt;
   logic [PW-1:0]   rrPtr, rrPtrNxt;
   logic [PW-1:0]   owner, ownerNxt;
   logic            lockFlag, lockFlagNxt;
   logic [CW-1:0]   cnt, cntNxt;
   logic [NREQ-1:0] gntNxt, ackNxt;
   logic            errNxt, busValidNxt, busWriteNxt;
   logic [31:0]     rDataNxt, busAddrNxt, busWDataNxt;
   logic            found;
   logic [PW-1:0]   win, cand;
   logic [PW+4:0]   sel;

   // State and output registers
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state     <= sIdle;
         rrPtr     <= PW'(NREQ - 1);
         owner     <= '0;
         lockFlag  <= 1'b0;
         cnt       <= '0;
         oGnt      <= '0;
         oAck      <= '0;
         oErr      <= 1'b0;
         oRData    <= '0;
         oBusValid <= 1'b0;
         oBusWrite <= 1'b0;
         oBusAddr  <= '0;
         oBusWData <= '0;
      end else begin
         state     <= stateNxt;
         rrPtr     <= rrPtrNxt;
         owner     <= ownerNxt;
         lockFlag  <= lockFlagNxt;
         cnt       <= cntNxt;
         oGnt      <= gntNxt;
         oAck      <= ackNxt;
         oErr      <= errNxt;
         oRData    <= rDataNxt;
         oBusValid <= busValidNxt;
         oBusWrite <= busWriteNxt;
         oBusAddr  <= busAddrNxt;
         oBusWData <= busWDataNxt;
      end
   end

   // Arbitration, bus sequencing and timeout
   always_comb begin
      stateNxt    = state;
      rrPtrNxt    = rrPtr;
      ownerNxt    = owner;
      lockFlagNxt = lockFlag;
      cntNxt      = cnt;
      gntNxt      = oGnt;
      ackNxt      = oAck;
      errNxt      = oErr;
      rDataNxt    = oRData;
      busValidNxt = oBusValid;
      busWriteNxt = oBusWrite;
      busAddrNxt  = oBusAddr;
      busWDataNxt = oBusWData;
      found       = 1'b0;
      win         = owner;
      cand        = '0;
      sel         = '0;

      case (state)
         sIdle: begin
            gntNxt = '0;
            if (lockFlag && iReq[owner]) begin
               found = 1'b1;
               win   = owner;
            end else begin
               // Lock lapses as soon as its owner stops requesting
               lockFlagNxt = 1'b0;
               for (int unsigned i = 1; i <= NREQ; i++) begin
                  cand = PW'((32'(rrPtr) + i) % NREQ);
                  if (!found && iReq[cand]) begin
                     found = 1'b1;
                     win   = cand;
                  end
               end
               if (found) rrPtrNxt = win;
            end
            if (found) begin
               sel         = {win, 5'd0};
               ownerNxt    = win;
               gntNxt      = NREQ'(1) << win;
               busValidNxt = 1'b1;
               busWriteNxt = iWrite[win];
               busAddrNxt  = iAddr[sel +: 32];
               busWDataNxt = iWData[sel +: 32];
               cntNxt      = '0;
               stateNxt    = sBus;
            end
         end
         sBus: begin
            cntNxt = cnt + CW'(1);
            // Ready on the timeout cycle still counts as a normal completion
            if (iBusReady) begin
               rDataNxt    = oBusWrite ? 32'h0 : iBusRData;
               errNxt      = 1'b0;
               ackNxt      = oGnt;
               busValidNxt = 1'b0;
               busWriteNxt = 1'b0;
               stateNxt    = sAck;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               rDataNxt    = ERR_DATA;
               errNxt      = 1'b1;
               ackNxt      = oGnt;
               busValidNxt = 1'b0;
               busWriteNxt = 1'b0;
               stateNxt    = sAck;
            end
         end
         sAck: begin
            ackNxt      = '0;
            gntNxt      = '0;
            lockFlagNxt = iLock[owner] & ~oErr;
            stateNxt    = sIdle;
         end
         default: stateNxt = sIdle;
      endcase
   end

endmodule
